ldtu_link_sequencer: RTL and testbench



---
 rtl/ldtu_link_sequencer_pkg.sv | 18 +
 rtl/ldtu_link_sequencer_if.sv | 25 ++
 rtl/ldtu_link_sequencer_frame_counter.sv | 29 ++
 rtl/ldtu_link_sequencer.sv | 158 +++++++++++++++
 tb/tb_ldtu_link_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ldtu_link_sequencer_pkg.sv
// Shared types and default constants for the LDTU link sequencer.
package ldtu_seq_pkg;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_CALIB  = 3'd1,
    S_NORMAL = 3'd2,
    S_GUARD  = 3'd3,
    S_TEST   = 3'd4
  } seq_state_t;

  localparam int unsigned SYNC_FRAMES_DEF    = 64;
  localparam int unsigned GUARD_FRAMES_DEF   = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;
  localparam int unsigned CNT_W_DEF          = 8;
  localparam int unsigned TO_W_DEF           = 13;

endpackage

// File: rtl/ldtu_link_sequencer_if.sv
// Request/status bundle between slow control, the sequencer and the output mux.
interface ldtu_link_sequencer_if;

  logic       CALIB_REQ;
  logic       CALIB_DONE;
  logic       TEST_REQ;
  logic       SYNC_REQ;
  logic       CALIBRATION_BUSY;
  logic       TEST_ENABLE;
  logic       CALIB_START;
  logic       SEQ_READY;
  logic [2:0] STATE;
  logic       CALIB_TIMEOUT;

  modport master (
    output CALIB_REQ, CALIB_DONE, TEST_REQ, SYNC_REQ,
    input  CALIBRATION_BUSY, TEST_ENABLE, CALIB_START, SEQ_READY, STATE, CALIB_TIMEOUT
  );

  modport slave (
    input  CALIB_REQ, CALIB_DONE, TEST_REQ, SYNC_REQ,
    output CALIBRATION_BUSY, TEST_ENABLE, CALIB_START, SEQ_READY, STATE, CALIB_TIMEOUT
  );

endinterface

// File: rtl/ldtu_link_sequencer_frame_counter.sv
// Clearable terminal-count counter; saturates at the terminal value and
// flags it, so it never wraps while the owner is still in its state.
module ldtu_frame_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  assign o_done = (r_cnt == i_term);

  // Count up while enabled, hold at terminal, clear has priority.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ldtu_link_sequencer.sv
// LDTU link sequencer: drives the CALIBRATION_BUSY / TEST_ENABLE mux selects,
// sequencing sync -> calibration -> normal <-> test with idle guard periods.
// Optional calibration timeout enabled by defining LDTU_SEQ_TIMEOUT_EN.
module ldtu_link_sequencer
  import ldtu_seq_pkg::*;
#(
  parameter int unsigned SYNC_FRAMES    = SYNC_FRAMES_DEF,
  parameter int unsigned GUARD_FRAMES   = GUARD_FRAMES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W           = TO_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  ldtu_link_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SYNC_TERM  = CNT_W'(SYNC_FRAMES - 1);
  localparam logic [CNT_W-1:0] GUARD_TERM = CNT_W'(GUARD_FRAMES - 1);
  localparam logic [TO_W-1:0]  TO_TERM    = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  seq_state_t       r_guard_tgt;
  seq_state_t       w_tgt_nxt;
  logic             r_busy;
  logic             r_test;
  logic             r_start;
  logic             r_ready;
  logic             r_timeout;
  logic             r_pend;
  logic             w_pend_nxt;
  logic             w_timeout_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_cnt_done;
  logic [CNT_W-1:0] w_cnt_term;
  logic             w_to_en;
  logic             w_to_done;

  // Any state change (including recovery from an illegal code) restarts both counts.
  assign w_cnt_clr  = (w_state_nxt != r_state);
  assign w_cnt_en   = (r_state == S_SYNC) || (r_state == S_GUARD);
  assign w_cnt_term = (r_state == S_GUARD) ? GUARD_TERM : SYNC_TERM;

`ifdef LDTU_SEQ_TIMEOUT_EN
  assign w_to_en = (r_state == S_CALIB);
`else
  // Counter never leaves zero, so the timeout can never fire.
  assign w_to_en = 1'b0;
`endif

  ldtu_frame_counter #(.W(CNT_W)) u_frame_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_term (w_cnt_term),
    .o_done (w_cnt_done)
  );

  ldtu_frame_counter #(.W(TO_W)) u_timeout_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_cnt_clr),
    .i_en   (w_to_en),
    .i_term (TO_TERM),
    .o_done (w_to_done)
  );

  // Next-state, pending-calibration, guard-target and timeout-flag decisions.
  always_comb begin
    w_state_nxt   = S_SYNC;
    w_tgt_nxt     = r_guard_tgt;
    w_pend_nxt    = r_pend;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_SYNC: begin
        if (bus.CALIB_REQ) w_pend_nxt = 1'b1;
        w_state_nxt = w_cnt_done ? S_CALIB : S_SYNC;
      end
      S_CALIB: begin
        // r_start marks the first calibration cycle, where CALIB_DONE is stale.
        if (!r_start && bus.CALIB_DONE) begin
          w_state_nxt   = S_NORMAL;
          w_pend_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
        end else if (w_to_done) begin
          w_state_nxt   = S_NORMAL;
          w_pend_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = S_CALIB;
        end
      end
      S_NORMAL: begin
        if (bus.CALIB_REQ || r_pend) begin
          w_state_nxt = S_CALIB;
        end else if (bus.SYNC_REQ) begin
          w_state_nxt = S_SYNC;
        end else if (bus.TEST_REQ) begin
          w_state_nxt = S_GUARD;
          w_tgt_nxt   = S_TEST;
        end else begin
          w_state_nxt = S_NORMAL;
        end
      end
      S_GUARD: begin
        if (bus.CALIB_REQ) w_pend_nxt = 1'b1;
        w_state_nxt = w_cnt_done ? r_guard_tgt : S_GUARD;
      end
      S_TEST: begin
        if (bus.CALIB_REQ) w_pend_nxt = 1'b1;
        if (bus.SYNC_REQ) begin
          w_state_nxt = S_SYNC;
        end else if (!bus.TEST_REQ) begin
          w_state_nxt = S_GUARD;
          w_tgt_nxt   = S_NORMAL;
        end else begin
          w_state_nxt = S_TEST;
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= S_SYNC;
      r_guard_tgt <= S_NORMAL;
      r_pend      <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b1;
      r_test      <= 1'b0;
      r_start     <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_guard_tgt <= w_tgt_nxt;
      r_pend      <= w_pend_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt == S_SYNC) || (w_state_nxt == S_CALIB) ||
                     (w_state_nxt == S_GUARD);
      r_test      <= (w_state_nxt == S_TEST);
      r_start     <= (w_state_nxt == S_CALIB) && (r_state != S_CALIB);
      r_ready     <= (w_state_nxt == S_NORMAL);
    end
  end

  assign bus.CALIBRATION_BUSY = r_busy;
  assign bus.TEST_ENABLE      = r_test;
  assign bus.CALIB_START      = r_start;
  assign bus.SEQ_READY        = r_ready;
  assign bus.STATE            = r_state;
  assign bus.CALIB_TIMEOUT    = r_timeout;

endmodule

// File: tb/tb_ldtu_link_sequencer.sv
// Self-checking bench for ldtu_link_sequencer: vector table plus hand-written
// reset/timeout sequences, expected values queued and compared after each edge.
module tb_ldtu_link_sequencer;

  localparam logic [2:0] ST_SYNC   = 3'd0;
  localparam logic [2:0] ST_CALIB  = 3'd1;
  localparam logic [2:0] ST_NORMAL = 3'd2;
  localparam logic [2:0] ST_GUARD  = 3'd3;
  localparam logic [2:0] ST_TEST   = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic       busy;
    logic       test;
    logic       start;
    logic       ready;
    logic       to;
  } exp_t;

  typedef struct {
    logic  creq;
    logic  cdone;
    logic  treq;
    logic  sreq;
    exp_t  e;
    int    reps;
    string nm;
  } vec_t;

  typedef struct {
    exp_t  e;
    string nm;
  } sb_t;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  vec_t tbl[$];
  sb_t  sb_q[$];

  ldtu_link_sequencer_if bus ();

  ldtu_link_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want finish before limit");
    $fatal(1);
  end

  function automatic exp_t ex(input logic [2:0] st, input logic start, input logic to);
    exp_t r;
    r.st    = st;
    r.busy  = (st == ST_SYNC) || (st == ST_CALIB) || (st == ST_GUARD);
    r.test  = (st == ST_TEST);
    r.start = start;
    r.ready = (st == ST_NORMAL);
    r.to    = to;
    return r;
  endfunction

  task automatic check();
    sb_t  s;
    exp_t act;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue, want one entry");
      return;
    end
    s = sb_q.pop_front();
    act.st    = bus.STATE;
    act.busy  = bus.CALIBRATION_BUSY;
    act.test  = bus.TEST_ENABLE;
    act.start = bus.CALIB_START;
    act.ready = bus.SEQ_READY;
    act.to    = bus.CALIB_TIMEOUT;
    total++;
    if (act !== s.e) begin
      bad++;
      $display("FAIL %s: got st=%0d busy=%b test=%b start=%b ready=%b to=%b, want st=%0d busy=%b test=%b start=%b ready=%b to=%b",
               s.nm, act.st, act.busy, act.test, act.start, act.ready, act.to,
               s.e.st, s.e.busy, s.e.test, s.e.start, s.e.ready, s.e.to);
    end
  endtask

  task automatic step(input logic creq, input logic cdone, input logic treq,
                      input logic sreq, input exp_t e, input string nm);
    sb_t s;
    bus.CALIB_REQ  = creq;
    bus.CALIB_DONE = cdone;
    bus.TEST_REQ   = treq;
    bus.SYNC_REQ   = sreq;
    s.e  = e;
    s.nm = nm;
    sb_q.push_back(s);
    @(posedge CLK);
    #1;
    check();
  endtask

  task automatic add(input logic creq, input logic cdone, input logic treq,
                     input logic sreq, input logic [2:0] st, input logic start,
                     input int reps, input string nm);
    vec_t v;
    v.creq  = creq;
    v.cdone = cdone;
    v.treq  = treq;
    v.sreq  = sreq;
    v.e     = ex(st, start, 1'b0);
    v.reps  = reps;
    v.nm    = nm;
    tbl.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    bus.CALIB_REQ  = 1'b0;
    bus.CALIB_DONE = 1'b0;
    bus.TEST_REQ   = 1'b0;
    bus.SYNC_REQ   = 1'b0;

    // Table: starts from S_NORMAL reached by the power-up sequence below.
    add(0,0,1,0, ST_GUARD,  0, 8,  "guard_to_test");
    add(0,0,1,0, ST_TEST,   0, 3,  "test_hold");
    add(0,0,0,0, ST_GUARD,  0, 8,  "guard_to_norm");
    add(0,0,0,0, ST_NORMAL, 0, 2,  "back_normal");
    add(0,0,1,0, ST_GUARD,  0, 1,  "guard_latch");
    add(0,0,0,0, ST_GUARD,  0, 7,  "guard_latch_hold");
    add(0,0,0,0, ST_TEST,   0, 1,  "latched_test");
    add(0,0,0,0, ST_GUARD,  0, 8,  "test_exit");
    add(0,0,0,0, ST_NORMAL, 0, 1,  "latched_norm");
    add(1,0,0,1, ST_CALIB,  1, 1,  "calib_over_sync");
    add(0,0,0,0, ST_CALIB,  0, 2,  "calib_wait");
    add(0,1,0,0, ST_NORMAL, 0, 1,  "calib_done");
    add(0,0,0,0, ST_NORMAL, 0, 2,  "no_sync_burst");
    add(1,0,1,0, ST_CALIB,  1, 1,  "calib_over_test");
    add(0,1,0,0, ST_CALIB,  0, 1,  "done_ignored_on_start");
    add(0,1,0,0, ST_NORMAL, 0, 1,  "done_accepted");
    add(0,0,0,0, ST_NORMAL, 0, 1,  "normal_idle");
    add(0,0,1,1, ST_SYNC,   0, 1,  "sync_over_test");
    add(0,0,0,1, ST_SYNC,   0, 10, "sync_in_sync_drop");
    add(1,0,0,0, ST_SYNC,   0, 1,  "creq_in_sync");
    add(0,0,0,0, ST_SYNC,   0, 52, "sync_burst");
    add(0,0,0,0, ST_CALIB,  1, 1,  "calib_after_sync");
    add(1,0,0,0, ST_CALIB,  0, 1,  "creq_in_calib_drop");
    add(0,1,0,0, ST_NORMAL, 0, 1,  "calib_done3");
    add(0,0,0,0, ST_NORMAL, 0, 3,  "pending_cleared");
    add(0,0,1,0, ST_GUARD,  0, 8,  "guard_to_test2");
    add(0,0,1,0, ST_TEST,   0, 1,  "test2");
    add(0,0,1,1, ST_SYNC,   0, 1,  "sync_from_test");
    add(0,0,1,1, ST_SYNC,   0, 5,  "sync_drop2");
    add(0,0,0,0, ST_SYNC,   0, 58, "sync_burst2");
    add(0,1,0,0, ST_CALIB,  1, 1,  "calib_after_sync2");
    add(0,0,0,0, ST_CALIB,  0, 1,  "calib_wait2");
    add(0,1,0,0, ST_NORMAL, 0, 1,  "calib_done4");
    add(0,0,1,0, ST_GUARD,  0, 8,  "guard_to_test3");
    add(0,0,1,0, ST_TEST,   0, 1,  "test3");
    add(1,0,1,0, ST_TEST,   0, 1,  "creq_in_test");
    add(0,0,1,0, ST_TEST,   0, 2,  "test3_hold");
    add(0,0,0,0, ST_GUARD,  0, 8,  "guard_pending");
    add(0,0,0,0, ST_NORMAL, 0, 1,  "one_normal");
    add(0,0,0,0, ST_CALIB,  1, 1,  "pending_served");
    add(0,0,0,0, ST_CALIB,  0, 1,  "calib_wait3");
    add(0,1,0,0, ST_NORMAL, 0, 1,  "calib_done5");
    add(0,0,1,0, ST_GUARD,  0, 1,  "guard_to_test4");
    add(1,0,1,0, ST_GUARD,  0, 1,  "creq_in_guard");
    add(0,0,1,0, ST_GUARD,  0, 6,  "guard4_hold");
    add(0,0,1,0, ST_TEST,   0, 2,  "pending_held_in_test");
    add(0,0,0,0, ST_GUARD,  0, 8,  "guard4_exit");
    add(0,0,0,0, ST_NORMAL, 0, 1,  "one_normal2");
    add(0,0,0,0, ST_CALIB,  1, 1,  "pending_served2");
    add(0,1,0,0, ST_CALIB,  0, 1,  "done_ignored2");
    add(0,1,0,0, ST_NORMAL, 0, 1,  "calib_done6");

    // Power-up: reset, 64-cycle idle burst, calibration handshake.
    step(0,0,0,0, ex(ST_SYNC, 0, 0), "reset_state");
    step(1,1,1,1, ex(ST_SYNC, 0, 0), "reset_holds");
    RST = 1'b1;
    for (int i = 0; i < 63; i++) step(0,0,0,0, ex(ST_SYNC, 0, 0), "powerup_sync");
    step(0,0,0,0, ex(ST_CALIB, 1, 0), "powerup_calib_start");
    for (int i = 0; i < 9; i++) step(0,0,0,0, ex(ST_CALIB, 0, 0), "powerup_calib_wait");
    step(0,1,0,0, ex(ST_NORMAL, 0, 0), "powerup_normal");

    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].reps; r++)
        step(tbl[k].creq, tbl[k].cdone, tbl[k].treq, tbl[k].sreq, tbl[k].e, tbl[k].nm);
    end

    // Reset in the middle of a guard period.
    for (int i = 0; i < 3; i++) step(0,0,1,0, ex(ST_GUARD, 0, 0), "guard_before_reset");
    RST = 1'b0;
    step(0,0,1,0, ex(ST_SYNC, 0, 0), "reset_mid_guard");
    RST = 1'b1;
    for (int i = 0; i < 63; i++) step(0,0,1,0, ex(ST_SYNC, 0, 0), "resync_after_reset");
    step(0,0,0,0, ex(ST_CALIB, 1, 0), "recalib_start");

`ifdef LDTU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 4095; i++) step(0,0,0,0, ex(ST_CALIB, 0, 0), "timeout_wait");
    step(0,0,0,0, ex(ST_NORMAL, 0, 1), "timeout_fired");
    step(1,0,0,0, ex(ST_CALIB, 1, 1), "timeout_sticky_calib");
    step(0,0,0,0, ex(ST_CALIB, 0, 1), "timeout_sticky_wait");
    step(0,1,0,0, ex(ST_NORMAL, 0, 0), "timeout_cleared");
`else
    for (int i = 0; i < 300; i++) step(0,0,0,0, ex(ST_CALIB, 0, 0), "calib_no_timeout");
    step(0,1,0,0, ex(ST_NORMAL, 0, 0), "late_calib_done");
`endif

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
